clk_en_synth: RTL

- Parametrised successor to the fixed-ratio PLL wrapper: NUM_CH-channel fractional clock-enable synthesiser running entirely in the refclk domain.
- Each channel is a phase accumulator that produces single-cycle enables at rate inc/2^ACC_W × f_refclk.
- Increments are reprogrammable at runtime through a valid/ready port, and a PLL-style locked output gates all enables while the channels settle.
- Feeds core sub-domains (CPU/PPU/APU strobes) that need runtime-selectable rates without a PLL reconfiguration.

---
 rtl/clk_en_synth_pkg.sv | 17 +
 rtl/clk_en_acc.sv | 42 ++++
 rtl/clk_en_synth.sv | 110 +++++++++++
 3 files changed

// File: rtl/clk_en_synth_pkg.sv
// Shared types and sizing helpers for the fractional clock-enable synthesiser.
package clk_en_synth_pkg;

    typedef enum logic [0:0] {
        LOCKING = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int c);
        return $clog2(c + 1);
    endfunction

endpackage

// File: rtl/clk_en_acc.sv
// Single-channel phase accumulator: increment register, carry and enable flop.
module clk_en_acc
#(
    parameter int               ACC_W    = 32,
    parameter logic [ACC_W-1:0] INIT_INC = '0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic             reload,
    input  logic [ACC_W-1:0] reload_val,
    output logic             en
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic             carry;

    assign {carry, sum} = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            inc <= INIT_INC;
            en  <= 1'b0;
        end else begin
            if (load)
                inc <= load_inc;
            // Reload realigns the phase; the pending carry is dropped.
            if (reload) begin
                acc <= reload_val;
                en  <= 1'b0;
            end else begin
                acc <= sum;
                en  <= carry;
            end
        end
    end

endmodule

// File: rtl/clk_en_synth.sv
// NUM_CH-channel fractional clock-enable synthesiser with lock gating.
// Optional macro CLK_EN_SYNTH_PHASE_EN adds per-channel reload phases.
module clk_en_synth
    import clk_en_synth_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = {NUM_CH{32'h8000_0000}},
    localparam int CH_W = ch_w(NUM_CH)
)(
    input  logic              refclk,
    input  logic              rst,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
`ifdef CLK_EN_SYNTH_PHASE_EN
    input  logic [ACC_W-1:0]  cfg_phase,
`endif
    output logic              cfg_err
);

    localparam int CNT_W = cnt_w(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] en_r;
    logic              accept;
    logic              ch_ok;
    logic              reload;

    assign accept = cfg_valid && cfg_ready;
    assign ch_ok  = (32'(cfg_ch) < NUM_CH);
    assign reload = accept && ch_ok;
    assign clk_en = en_r & {NUM_CH{locked}};

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= LOCKING;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                LOCKING: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (accept && ch_ok) begin
                        state     <= LOCKING;
                        cnt       <= '0;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end else if (accept) begin
                        cfg_err <= 1'b1;
                    end
                end
                default: state <= LOCKING;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sel;
        logic [ACC_W-1:0] rld;

        assign sel = (cfg_ch == CH_W'(i));

`ifdef CLK_EN_SYNTH_PHASE_EN
        logic [ACC_W-1:0] phase_q;

        always_ff @(posedge refclk or posedge rst) begin
            if (rst)
                phase_q <= '0;
            else if (reload && sel)
                phase_q <= cfg_phase;
        end

        // The target channel reloads with the phase being written this cycle.
        assign rld = sel ? cfg_phase : phase_q;
`else
        assign rld = '0;
`endif

        clk_en_acc #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC[i*ACC_W +: ACC_W])
        ) u_acc (
            .clk        (refclk),
            .rst        (rst),
            .load       (reload && sel),
            .load_inc   (cfg_inc),
            .reload     (reload),
            .reload_val (rld),
            .en         (en_r[i])
        );
    end

endmodule
